// File: rtl/serial_right_shifter.sv
// Multi-cycle right shift/rotate unit (ASR, LSR, ROR, RCR) with a start/busy/done handshake.
// Define FAST_NIBBLE_EN to retire up to four bit positions per SHIFT cycle.
module serial_right_shifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] sramt,
  input  logic             carry_in,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] M_ASR = 2'b00;
  localparam logic [1:0] M_LSR = 2'b01;
  localparam logic [1:0] M_ROR = 2'b10;
  localparam logic [1:0] M_RCR = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic [1:0]       mode_q, mode_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;

  // One 1-bit step on the packed {out, carry} word; the bit leaving out[0] always lands in carry.
  function automatic logic [WIDTH:0] step1(input logic [WIDTH:0] v, input logic [1:0] m);
    logic msb;
    case (m)
      M_ASR:   msb = v[WIDTH];
      M_LSR:   msb = 1'b0;
      M_ROR:   msb = v[1];
      M_RCR:   msb = v[0];
      default: msb = 1'b0;
    endcase
    return {msb, v[WIDTH:2], v[1]};
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    out_d   = out_q;
    carry_d = carry_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          out_d   = in;
          carry_d = carry_in;
          mode_d  = mode;
          cnt_d   = sramt;
          state_d = (sramt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
`ifdef FAST_NIBBLE_EN
        if (cnt_q >= AMT_W'(4)) begin
          {out_d, carry_d} = step1(step1(step1(step1({out_q, carry_q}, mode_q), mode_q),
                                         mode_q), mode_q);
          cnt_d = cnt_q - AMT_W'(4);
        end else begin
          {out_d, carry_d} = step1({out_q, carry_q}, mode_q);
          cnt_d = cnt_q - AMT_W'(1);
        end
        if (cnt_d == '0) state_d = S_DONE;
`else
        {out_d, carry_d} = step1({out_q, carry_q}, mode_q);
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) state_d = S_DONE;
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      carry_q <= 1'b0;
      mode_q  <= M_ASR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out       = out_q;
  assign carry_out = carry_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_right_shifter.sv
// Directed-vector bench for serial_right_shifter; expected results are hand-computed constants.
// Cycle timing expectations follow FAST_NIBBLE_EN when it is defined.
module tb_serial_right_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] in;
  logic [1:0]  mode;
  logic [4:0]  sramt;
  logic        carry_in;
  logic [15:0] out;
  logic        carry_out;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [1:0] ASR = 2'b00;
  localparam logic [1:0] LSR = 2'b01;
  localparam logic [1:0] ROR = 2'b10;
  localparam logic [1:0] RCR = 2'b11;

  serial_right_shifter #(.WIDTH(16), .AMT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .in(in), .mode(mode), .sramt(sramt),
    .carry_in(carry_in), .out(out), .carry_out(carry_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_done_cycle(input int amt);
`ifdef FAST_NIBBLE_EN
    return amt / 4 + amt % 4 + 1;
`else
    return amt + 1;
`endif
  endfunction

  // Called just after a falling edge; start is accepted at the next rising edge (end of cycle 0).
  // A start pulse with scrambled operands is driven in cycle 'inject' (0 = none).
  task automatic run_op(input string tag, input logic [1:0] m, input logic [15:0] a,
                        input logic [4:0] amt, input logic cin, input logic [15:0] eo,
                        input logic ec, input int inject);
    int ed;
    int done_at;
    int done_cnt;
    int busy_err;
    ed       = exp_done_cycle(int'(amt));
    done_at  = 0;
    done_cnt = 0;
    busy_err = 0;
    start    = 1'b1;
    in       = a;
    mode     = m;
    sramt    = amt;
    carry_in = cin;
    @(negedge clk);
    for (int cyc = 1; cyc <= ed + 1; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (busy !== (cyc <= ed)) busy_err++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = cyc;
      end
      if (cyc == ed) begin
        check({tag, "/out"}, 32'(out), 32'(eo));
        check({tag, "/carry"}, 32'(carry_out), 32'(ec));
      end
      if (cyc == ed + 1) check({tag, "/hold"}, {15'd0, carry_out, out}, {15'd0, ec, eo});
      start    = (cyc == inject);
      in       = ~a;
      mode     = ~m;
      sramt    = 5'd7;
      carry_in = ~cin;
    end
    start = 1'b0;
    check({tag, "/done_cycle"}, 32'(done_at), 32'(ed));
    check({tag, "/done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "/busy_window"}, 32'(busy_err), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b1;
    in       = 16'hFFFF;
    mode     = RCR;
    sramt    = 5'd3;
    carry_in = 1'b1;
    repeat (2) @(negedge clk);
    check("reset/out", 32'(out), 32'h0);
    check("reset/carry", 32'(carry_out), 32'h0);
    check("reset/busy", 32'(busy), 32'h0);
    check("reset/done", 32'(done), 32'h0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);

    run_op("asr3",     ASR, 16'h8004, 5'd3,  1'b0, 16'hF000, 1'b1, 0);
    run_op("lsr20",    LSR, 16'hFFFF, 5'd20, 1'b0, 16'h0000, 1'b0, 0);
    run_op("ror1",     ROR, 16'h0001, 5'd1,  1'b0, 16'h8000, 1'b1, 0);
    run_op("ror16",    ROR, 16'h0001, 5'd16, 1'b0, 16'h0001, 1'b0, 0);
    run_op("rcr1",     RCR, 16'h0001, 5'd1,  1'b0, 16'h0000, 1'b1, 0);
    run_op("rcr2",     RCR, 16'h0001, 5'd2,  1'b0, 16'h8000, 1'b0, 0);
    run_op("rcr17",    RCR, 16'h0001, 5'd17, 1'b0, 16'h0001, 1'b0, 0);
    run_op("amt0",     ASR, 16'h1234, 5'd0,  1'b1, 16'h1234, 1'b1, 0);
    run_op("ror5_ign", ROR, 16'h00F0, 5'd5,  1'b0, 16'h8007, 1'b1, 2);
    run_op("asr31",    ASR, 16'h8000, 5'd31, 1'b0, 16'hFFFF, 1'b1, 0);
    run_op("lsr16",    LSR, 16'h8000, 5'd16, 1'b1, 16'h0000, 1'b1, 0);
    run_op("rcr4_ign", RCR, 16'hFFFF, 5'd4,  1'b0, 16'hEFFF, 1'b1, exp_done_cycle(4));
    run_op("asr4",     ASR, 16'h7FF0, 5'd4,  1'b1, 16'h07FF, 1'b0, 0);

    // Reset in cycle 3 of an LSR-by-10 operation.
    start    = 1'b1;
    in       = 16'hABCD;
    mode     = LSR;
    sramt    = 5'd10;
    carry_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midop/busy", 32'(busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst/out", 32'(out), 32'h0);
    check("midrst/carry", 32'(carry_out), 32'h0);
    check("midrst/busy", 32'(busy), 32'h0);
    check("midrst/done", 32'(done), 32'h0);
    rst = 1'b0;
    run_op("post_rst", LSR, 16'h00FF, 5'd4, 1'b0, 16'h000F, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
